// File: rtl/lcd_spi_arbiter_if.sv
// Byte channels between the two LCD requesters, the arbiter
// and the shared SPI byte engine.
interface lcd_spi_arbiter_if;
  logic       R0_REQ;
  logic       R0_VALID;
  logic [7:0] R0_DATA;
  logic       R0_DC;
  logic       R0_LAST;
  logic       R0_READY;
  logic       R0_GNT;
  logic       R1_REQ;
  logic       R1_VALID;
  logic [7:0] R1_DATA;
  logic       R1_DC;
  logic       R1_LAST;
  logic       R1_READY;
  logic       R1_GNT;
  logic       TX_VALID;
  logic [7:0] TX_DATA;
  logic       TX_DC;
  logic       TX_LAST;
  logic       TX_READY;
  logic       TX_ABORT;

  modport slave (
    input  R0_REQ, R0_VALID, R0_DATA,
    input  R0_DC, R0_LAST,
    output R0_READY, R0_GNT,
    input  R1_REQ, R1_VALID, R1_DATA,
    input  R1_DC, R1_LAST,
    output R1_READY, R1_GNT,
    output TX_VALID, TX_DATA, TX_DC,
    output TX_LAST, TX_ABORT,
    input  TX_READY
  );

  modport master (
    output R0_REQ, R0_VALID, R0_DATA,
    output R0_DC, R0_LAST,
    input  R0_READY, R0_GNT,
    output R1_REQ, R1_VALID, R1_DATA,
    output R1_DC, R1_LAST,
    input  R1_READY, R1_GNT,
    input  TX_VALID, TX_DATA, TX_DC,
    input  TX_LAST, TX_ABORT,
    output TX_READY
  );
endinterface

// File: rtl/lcd_spi_arbiter.sv
// Transaction-atomic arbiter sharing one LCD SPI byte engine
// between the init sequencer (R0) and the pixel streamer (R1).
module lcd_spi_arbiter #(
  parameter int unsigned FAIR_LIMIT = 4,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic             CLK,
  input  logic             RST_N,
  lcd_spi_arbiter_if.slave bus,
  output logic             OWNER,
  output logic             BUSY,
  output logic             ERR
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RELEASE
  } state_t;

  localparam logic [3:0]  FAIR_MAX = 4'(FAIR_LIMIT);
  localparam logic [15:0] TMO_END  = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  fair_q, fair_d;
  logic [15:0] tmo_q, tmo_d;
  logic        first_q, first_d;
  logic        err_q, err_d;

  logic       own_valid, own_dc, own_last;
  logic [7:0] own_data;
  logic       xfer, hs, pick_r1;

  always_comb begin
    own_valid = owner_q ? bus.R1_VALID : bus.R0_VALID;
    own_data  = owner_q ? bus.R1_DATA  : bus.R0_DATA;
    own_dc    = owner_q ? bus.R1_DC    : bus.R0_DC;
    own_last  = owner_q ? bus.R1_LAST  : bus.R0_LAST;
  end

  assign xfer  = (state_q == XFER);
  assign hs    = xfer & own_valid & bus.TX_READY;
  assign OWNER = owner_q;
  assign BUSY  = (state_q != IDLE);
  assign ERR   = err_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      fair_q  <= '0;
      tmo_q   <= '0;
      first_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      fair_q  <= fair_d;
      tmo_q   <= tmo_d;
      first_q <= first_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    fair_d       = fair_q;
    tmo_d        = tmo_q;
    first_d      = first_q;
    err_d        = err_q;
    pick_r1      = 1'b0;
    bus.R0_GNT   = 1'b0;
    bus.R1_GNT   = 1'b0;
    bus.R0_READY = 1'b0;
    bus.R1_READY = 1'b0;
    bus.TX_VALID = 1'b0;
    bus.TX_DATA  = '0;
    bus.TX_DC    = 1'b0;
    bus.TX_LAST  = 1'b0;
    bus.TX_ABORT = 1'b0;

    case (state_q)
      IDLE: begin
        // R1 forced in once R0 has used up its fairness budget
        pick_r1 = bus.R1_REQ &
                  (!bus.R0_REQ || fair_q == FAIR_MAX);
        if (bus.R0_REQ || bus.R1_REQ) begin
          state_d = XFER;
          owner_d = pick_r1;
          tmo_d   = '0;
          first_d = 1'b1;
          if (pick_r1 || !bus.R1_REQ)
            fair_d = '0;
          else if (fair_q != 4'hF)
            fair_d = fair_q + 4'd1;
        end
      end

      XFER: begin
        bus.R0_GNT   = !owner_q;
        bus.R1_GNT   = owner_q;
        bus.R0_READY = !owner_q & bus.TX_READY;
        bus.R1_READY = owner_q & bus.TX_READY;
        bus.TX_VALID = own_valid;
        bus.TX_DATA  = own_data;
        bus.TX_DC    = own_dc;
        bus.TX_LAST  = own_last;
        if (hs) begin
          tmo_d   = '0;
          first_d = 1'b0;
          if (first_q && own_dc)
            err_d = 1'b1;
          if (own_last)
            state_d = RELEASE;
        end else if (!own_valid) begin
          if (tmo_q == TMO_END) begin
            bus.TX_ABORT = 1'b1;
            err_d        = 1'b1;
            state_d      = RELEASE;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
      end

      RELEASE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

endmodule
